johnson_phase_tracker: RTL and testbench

Downstream consumer of the 4-bit Johnson ring counter output. It samples the Johnson code and produces the following:
- Binary phase index and one-hot phase.
- A lock state machine that confirms the sequence advances legally.
- Revolution counting with a wrap pulse.
- Sticky error flags for illegal codes and skipped steps.

Feeds phase-sequenced control logic that must not act on a corrupted ring.

---
 rtl/johnson_phase_tracker.sv | 150 +++++++++++++++
 tb/tb_johnson_phase_tracker.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/johnson_phase_tracker.sv
// Tracks a Johnson ring counter: decodes phase, confirms legal advance before
// locking, counts revolutions and latches sticky illegal-code / skip errors.
module johnson_phase_tracker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_STEPS = 3,
  parameter int REV_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [WIDTH-1:0]              jc_in,
  input  logic                          err_clr,
  output logic [$clog2(2*WIDTH)-1:0]    phase,
  output logic [2*WIDTH-1:0]            phase_onehot,
  output logic                          phase_valid,
  output logic                          locked,
  output logic                          wrap,
  output logic [REV_W-1:0]              rev_count,
  output logic                          err_illegal,
  output logic                          err_skip
);

  localparam int SEQ = 2 * WIDTH;
  localparam int PW  = $clog2(SEQ);
  localparam int SW  = $clog2(LOCK_STEPS + 1);

  localparam logic ST_UNLOCK = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  localparam logic [WIDTH-1:0] CODE_ONE = 1;
  localparam logic [SEQ-1:0]   OH_ONE   = 1;
  localparam logic [REV_W-1:0] REV_ONE  = 1;
  localparam logic [SW-1:0]    STEP_ONE = 1;
  localparam logic [PW-1:0]    PH_ONE   = 1;
  localparam logic [PW-1:0]    PH_LAST  = PW'(SEQ - 1);
  localparam logic [SW-1:0]    STEP_LAST = SW'(LOCK_STEPS - 1);

  logic             state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [SEQ-1:0]   onehot_q, onehot_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic             err_ill_q, err_ill_d;
  logic             err_skip_q, err_skip_d;

  // Folding msb=1 codes by inversion turns both halves into "ones from LSB".
  logic [WIDTH-1:0] norm;
  logic             legal;
  logic [PW-1:0]    ones;
  logic [PW-1:0]    dec_phase;
  logic [PW-1:0]    inc_phase;

  always_comb begin
    norm  = jc_in[WIDTH-1] ? ~jc_in : jc_in;
    legal = ((norm + CODE_ONE) & norm) == '0;
    ones  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones = ones + PW'(norm[i]);
    end
    dec_phase = jc_in[WIDTH-1] ? (PW'(WIDTH) + ones) : ones;
    inc_phase = (phase_q == PH_LAST) ? '0 : (phase_q + PH_ONE);
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    phase_d    = phase_q;
    onehot_d   = onehot_q;
    valid_d    = valid_q;
    wrap_d     = 1'b0;
    rev_d      = rev_q;
    err_ill_d  = err_ill_q & ~err_clr;
    err_skip_d = err_skip_q & ~err_clr;

    if (en) begin
      if (!legal) begin
        // Phase keeps its last legal value; only validity and one-hot drop.
        err_ill_d = 1'b1;
        state_d   = ST_UNLOCK;
        step_d    = '0;
        valid_d   = 1'b0;
        onehot_d  = '0;
      end else if (state_q == ST_UNLOCK) begin
        phase_d  = dec_phase;
        onehot_d = OH_ONE << dec_phase;
        valid_d  = 1'b1;
        if (valid_q && dec_phase == inc_phase) begin
          if (step_q == STEP_LAST) begin
            state_d = ST_LOCKED;
            step_d  = '0;
          end else begin
            step_d = step_q + STEP_ONE;
          end
        end else if (!(valid_q && dec_phase == phase_q)) begin
          step_d = '0;
        end
      end else if (dec_phase == inc_phase) begin
        phase_d  = dec_phase;
        onehot_d = OH_ONE << dec_phase;
        if (phase_q == PH_LAST) begin
          wrap_d = 1'b1;
          rev_d  = rev_q + REV_ONE;
        end
      end else if (dec_phase != phase_q) begin
        err_skip_d = 1'b1;
        state_d    = ST_UNLOCK;
        step_d     = '0;
        phase_d    = dec_phase;
        onehot_d   = OH_ONE << dec_phase;
        valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_UNLOCK;
      step_q     <= '0;
      phase_q    <= '0;
      onehot_q   <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      rev_q      <= '0;
      err_ill_q  <= 1'b0;
      err_skip_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      phase_q    <= phase_d;
      onehot_q   <= onehot_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
      rev_q      <= rev_d;
      err_ill_q  <= err_ill_d;
      err_skip_q <= err_skip_d;
    end
  end

  assign phase        = phase_q;
  assign phase_onehot = onehot_q;
  assign phase_valid  = valid_q;
  assign locked       = (state_q == ST_LOCKED);
  assign wrap         = wrap_q;
  assign rev_count    = rev_q;
  assign err_illegal  = err_ill_q;
  assign err_skip     = err_skip_q;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Directed bench for johnson_phase_tracker with hand-computed expectations.
module tb_johnson_phase_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] jc_in;
  logic       err_clr;
  logic [2:0] phase;
  logic [7:0] phase_onehot;
  logic       phase_valid;
  logic       locked;
  logic       wrap;
  logic [7:0] rev_count;
  logic       err_illegal;
  logic       err_skip;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_wrap = 0;

  logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};

  johnson_phase_tracker #(.WIDTH(4), .LOCK_STEPS(3), .REV_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .jc_in(jc_in), .err_clr(err_clr),
    .phase(phase), .phase_onehot(phase_onehot), .phase_valid(phase_valid),
    .locked(locked), .wrap(wrap), .rev_count(rev_count),
    .err_illegal(err_illegal), .err_skip(err_skip)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample #1 after the edge.
  task automatic drive(input logic r, input logic e, input logic [3:0] jc, input logic clr);
    rst = r; en = e; jc_in = jc; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int ph, input logic vld, input logic lk,
                           input logic wr, input int rev, input logic ei, input logic es);
    logic [7:0] oh;
    oh = vld ? (8'd1 << ph) : 8'd0;
    check_val({tag, ".phase"},  32'(phase), 32'(ph));
    check_val({tag, ".onehot"}, 32'(phase_onehot), 32'(oh));
    check_val({tag, ".valid"},  32'(phase_valid), 32'(vld));
    check_val({tag, ".locked"}, 32'(locked), 32'(lk));
    check_val({tag, ".wrap"},   32'(wrap), 32'(wr));
    check_val({tag, ".rev"},    32'(rev_count), 32'(rev));
    check_val({tag, ".err_ill"}, 32'(err_illegal), 32'(ei));
    check_val({tag, ".err_skip"}, 32'(err_skip), 32'(es));
  endtask

  initial begin
    drive(1, 0, 4'b0000, 0);
    drive(1, 0, 4'b0000, 0);
    check_all("reset", 0, 0, 0, 0, 0, 0, 0);

    // Clean start: lock after the third +1 step
    drive(0, 1, 4'b0000, 0); check_all("s0", 0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 4'b0001, 0); check_all("s1", 1, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 4'b0011, 0); check_all("s2", 2, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 4'b0111, 0); check_all("s3", 3, 1, 1, 0, 0, 0, 0);

    drive(0, 1, 4'b1111, 0); check_all("s4", 4, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 4'b1110, 0); check_all("s5", 5, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 4'b1100, 0); check_all("s6", 6, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 4'b1000, 0); check_all("s7", 7, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 4'b0000, 0); check_all("wrap1", 0, 1, 1, 1, 1, 0, 0);
    drive(0, 1, 4'b0001, 0); check_all("post_wrap", 1, 1, 1, 0, 1, 0, 0);

    // 256 more revolutions: counter wraps back to 1
    for (int r = 0; r < 256; r++) begin
      for (int k = 2; k < 10; k++) begin
        drive(0, 1, codes[k % 8], 0);
        if (wrap) n_wrap++;
      end
    end
    check_val("wrap_count", n_wrap, 256);
    check_all("rev256", 1, 1, 1, 0, 1, 0, 0);

    // Illegal code while locked at phase 2
    drive(0, 1, 4'b0011, 0); check_all("pre_ill", 2, 1, 1, 0, 1, 0, 0);
    drive(0, 1, 4'b0101, 0); check_all("illegal", 2, 0, 0, 0, 1, 1, 0);
    drive(0, 1, 4'b0111, 0); check_all("rl0", 3, 1, 0, 0, 1, 1, 0);
    drive(0, 1, 4'b1111, 0); check_all("rl1", 4, 1, 0, 0, 1, 1, 0);
    drive(0, 1, 4'b1110, 0); check_all("rl2", 5, 1, 0, 0, 1, 1, 0);
    drive(0, 1, 4'b1100, 0); check_all("rl3", 6, 1, 1, 0, 1, 1, 0);
    drive(0, 1, 4'b1100, 1); check_all("clr_ill", 6, 1, 1, 0, 1, 0, 0);

    // Skip while locked at phase 1
    drive(0, 1, 4'b1000, 0); check_all("to7", 7, 1, 1, 0, 1, 0, 0);
    drive(0, 1, 4'b0000, 0); check_all("wrap2", 0, 1, 1, 1, 2, 0, 0);
    drive(0, 1, 4'b0001, 0); check_all("at1", 1, 1, 1, 0, 2, 0, 0);
    drive(0, 1, 4'b1111, 0); check_all("skip", 4, 1, 0, 0, 2, 0, 1);
    drive(0, 1, 4'b1111, 1); check_all("clr_skip", 4, 1, 0, 0, 2, 0, 0);
    drive(0, 1, 4'b0110, 1); check_all("clr_vs_ill", 4, 0, 0, 0, 2, 1, 0);

    // Relock, then en toggling and repeated codes
    drive(0, 1, 4'b0000, 0); check_all("r0", 0, 1, 0, 0, 2, 1, 0);
    drive(0, 1, 4'b0001, 0); check_all("r1", 1, 1, 0, 0, 2, 1, 0);
    drive(0, 1, 4'b0011, 0); check_all("r2", 2, 1, 0, 0, 2, 1, 0);
    drive(0, 1, 4'b0111, 0); check_all("r3", 3, 1, 1, 0, 2, 1, 0);
    drive(0, 0, 4'b1111, 0); check_all("en0_hold", 3, 1, 1, 0, 2, 1, 0);
    drive(0, 1, 4'b1111, 0); check_all("en1_adv", 4, 1, 1, 0, 2, 1, 0);
    drive(0, 1, 4'b1111, 0); check_all("repeat", 4, 1, 1, 0, 2, 1, 0);
    drive(0, 1, 4'b1110, 0);
    drive(0, 1, 4'b1100, 0);
    drive(0, 1, 4'b1000, 0); check_all("at7", 7, 1, 1, 0, 2, 1, 0);
    drive(0, 0, 4'b0000, 0); check_all("en0_nowrap", 7, 1, 1, 0, 2, 1, 0);
    drive(0, 0, 4'b0000, 0); check_all("en0_nowrap2", 7, 1, 1, 0, 2, 1, 0);
    drive(0, 1, 4'b0000, 0); check_all("wrap3", 0, 1, 1, 1, 3, 1, 0);
    drive(0, 0, 4'b0000, 0); check_all("wrap_forced0", 0, 1, 1, 0, 3, 1, 0);
    drive(0, 1, 4'b0000, 0); check_all("repeat0", 0, 1, 1, 0, 3, 1, 0);

    // Build up rev_count=5, both errors, locked; then reset
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k < 9; k++) drive(0, 1, codes[k % 8], 0);
    end
    check_all("rev5", 0, 1, 1, 1, 5, 1, 0);
    drive(0, 1, 4'b0011, 0); check_all("skip2", 2, 1, 0, 0, 5, 1, 1);
    drive(0, 1, 4'b0111, 0);
    drive(0, 1, 4'b1111, 0);
    drive(0, 1, 4'b1110, 0); check_all("pre_rst", 5, 1, 1, 0, 5, 1, 1);
    drive(1, 1, 4'b1100, 0); check_all("mid_rst", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 4'b0011, 0); check_all("pr0", 2, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 4'b0111, 0); check_all("pr1", 3, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 4'b1111, 0); check_all("pr2", 4, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 4'b1110, 0); check_all("pr3", 5, 1, 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
